// File: rtl/h264_intra_pkg.sv
// Shared types and helpers for the intra-prediction macroblock sequencer.
package h264_intra_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRED,
    ST_XFORM,
    ST_OUTW,
    ST_FBW,
    ST_NEXT,
    ST_CHROMA,
    ST_CWAIT,
    ST_DONE
  } intra_state_t;

  localparam logic MODE_4X4   = 1'b0;
  localparam logic MODE_16X16 = 1'b1;

  // Width of the transform latency counter; XFORM_LAT-1 must fit.
  localparam int CNT_W = 6;

  function automatic int submb_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/h264_intra_lat_cnt.sv
// Loadable down-counter with zero flag; times the transform stage.
module h264_intra_lat_cnt
  import h264_intra_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/h264_intra_seq_ctrl.sv
// Intra macroblock sequencer: walks luma sub-blocks through predict,
// transform, coefficient output and reconstruction feedback, then chroma.
module h264_intra_seq_ctrl
  import h264_intra_pkg::*;
#(
  parameter int NUM_SUBMB = 16,
  parameter int XFORM_LAT = 6,
  parameter int CHROMA_EN = 1,
  localparam int SW = submb_w(NUM_SUBMB)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mb_start,
  input  logic          mode16,
  input  logic          abort,
  input  logic          pred_ready,
  input  logic          out_ready,
  input  logic          fb_pending,
  input  logic          chroma_busy,
  output logic [SW-1:0] submb,
  output logic          pred_go,
  output logic          xform_go,
  output logic          out_valid,
  output logic          fb_req,
  output logic          chroma_go,
  output logic          busy,
  output logic          mb_done
);

  localparam logic [SW-1:0]    LAST_SUBMB = SW'(NUM_SUBMB - 1);
  localparam logic [CNT_W-1:0] LAT_M1     = CNT_W'(XFORM_LAT - 1);

  intra_state_t     state_q, state_d;
  logic [SW-1:0]    submb_q, submb_d;
  logic             m16_q, m16_d;
  logic             first_q, first_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_value;

  h264_intra_lat_cnt u_lat_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .value (cnt_value),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  // Coefficient handshake: out_valid stays high for the whole OUTW state and a
  // transfer happens only in a cycle with out_valid & out_ready & !fb_pending.
  always_comb begin
    state_d   = state_q;
    submb_d   = submb_q;
    m16_d     = m16_q;
    cnt_load  = 1'b0;
    cnt_value = LAT_M1;
    cnt_dec   = 1'b0;
    pred_go   = 1'b0;
    xform_go  = 1'b0;
    out_valid = 1'b0;
    fb_req    = 1'b0;
    chroma_go = 1'b0;
    mb_done   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mb_start) begin
          m16_d   = mode16;
          submb_d = '0;
          state_d = ST_PRED;
        end
      end
      ST_PRED: begin
        pred_go = pred_ready;
        if (pred_ready) begin
          cnt_load = 1'b1;
          state_d  = ST_XFORM;
        end
      end
      ST_XFORM: begin
        xform_go = first_q;
        cnt_dec  = 1'b1;
        if (cnt_zero) state_d = ST_OUTW;
      end
      ST_OUTW: begin
        out_valid = 1'b1;
        if (out_ready && !fb_pending) begin
          fb_req  = 1'b1;
          state_d = (m16_q == MODE_16X16) ? ST_NEXT : ST_FBW;
        end
      end
      ST_FBW: begin
        // fb_pending lags fb_req by a cycle, so the first cycle cannot decide.
        if (!first_q && !fb_pending) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (submb_q != LAST_SUBMB) begin
          submb_d = submb_q + 1'b1;
          state_d = ST_PRED;
        end else if (!fb_pending) begin
          state_d = (CHROMA_EN != 0) ? ST_CHROMA : ST_DONE;
        end
      end
      ST_CHROMA: begin
        chroma_go = 1'b1;
        state_d   = ST_CWAIT;
      end
      ST_CWAIT: begin
        if (!first_q && !chroma_busy) state_d = ST_DONE;
      end
      ST_DONE: begin
        mb_done = 1'b1;
        submb_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d   = ST_IDLE;
      submb_d   = '0;
      m16_d     = 1'b0;
      cnt_load  = 1'b1;
      cnt_value = '0;
      cnt_dec   = 1'b0;
      pred_go   = 1'b0;
      xform_go  = 1'b0;
      out_valid = 1'b0;
      fb_req    = 1'b0;
      chroma_go = 1'b0;
      mb_done   = 1'b0;
    end

    first_d = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      submb_q <= '0;
      m16_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      submb_q <= submb_d;
      m16_q   <= m16_d;
      first_q <= first_d;
    end
  end

  assign submb = submb_q;
  assign busy  = (state_q != ST_IDLE);

endmodule
